// File: rtl/sort_result_reader.sv
// Drains DEPTH result words after a rising sort_done; out_valid 3 cycles after the edge, 1 word / 3 cycles peak.
// Backpressure: SEND holds out_data/out_last until out_ready. Optional SORT_CHECK_EN adds a signed order checker.
module sort_result_reader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sort_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              drain_done,
  output logic              order_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    SEND  = 3'd3,
    FIN   = 3'd4,
    REARM = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              done_q;
  logic              start;
  logic              is_last;

  // done_q resets high so a level already present at reset release is not an edge
  assign start   = (state == IDLE) && sort_done && !done_q;
  assign is_last = (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      done_q   <= 1'b1;
      idx      <= '0;
      out_data <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= sort_done;
      if (start) begin
        idx <= '0;
      end else if (state == SEND && out_ready && !is_last) begin
        idx <= idx + 1'b1;
      end
      if (state == CAPT) begin
        out_data <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = idx;
        busy      = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: begin
        busy      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = is_last;
        if (out_ready) state_nxt = is_last ? FIN : READ;
      end
      FIN: begin
        drain_done = 1'b1;
        state_nxt  = REARM;
      end
      REARM: begin
        if (!sort_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SORT_CHECK_EN
  // out_data still holds the previous word while CAPT loads the new one
  always_ff @(posedge clock) begin
    if (!reset) begin
      order_err <= 1'b0;
    end else if (state == READ && idx == '0) begin
      order_err <= 1'b0;
    end else if (state == CAPT && idx != '0 &&
                 $signed(out_data) > $signed(mem_rdata)) begin
      order_err <= 1'b1;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_reader.sv
// Bench for sort_result_reader: table of drain scenarios plus reset / re-trigger sequences.
module tb_sort_result_reader;

  localparam int DEPTH = 32;
`ifdef SORT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        sort_done;
  logic        mem_rd_en;
  logic [4:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        drain_done;
  logic        order_err;

  always #5 clock = ~clock;

  sort_result_reader #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .sort_done(sort_done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .drain_done(drain_done),
    .order_err(order_err)
  );

  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clock) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct packed {
    logic        err;
    logic        last;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_head;
  int   n_checks = 0;
  int   n_fails = 0;
  int   words_seen = 0;
  int   stall_seen = 0;
  int   exp_addr = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Scoreboard: compares every presented word (including stalled cycles) with the queue head
  always @(negedge clock) begin
    if (reset) begin
      if (mem_rd_en) begin
        rd_cnt++;
        check("mem_addr", 64'(mem_addr), 64'(exp_addr));
        exp_addr++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_data), 64'hDEAD);
        end else begin
          exp_head = exp_q[0];
          check("out_data", 64'(out_data), 64'(exp_head.dat));
          check("out_last", 64'(out_last), 64'(exp_head.last));
          check("order_err", 64'(order_err), 64'(exp_head.err));
          if (out_ready) begin
            void'(exp_q.pop_front());
            words_seen++;
          end else begin
            stall_seen++;
          end
        end
      end
      if (drain_done) done_cnt++;
    end
  end

  task automatic fill_mem(input int base, input int bad_idx, input int bad_val);
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(base + i);
    if (bad_idx >= 0) mem[bad_idx] = 32'(bad_val);
  endtask

  task automatic start_drain(input bit keep_high);
    logic e;
    e = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CHK && i > 0 && $signed(mem[i-1]) > $signed(mem[i])) e = 1'b1;
      exp_q.push_back('{e, (i == DEPTH - 1), mem[i]});
    end
    words_seen = 0;
    stall_seen = 0;
    exp_addr   = 0;
    @(posedge clock); #1;
    sort_done = 1'b1;
    @(negedge clock);
    check("edge_cycle_busy", 64'(busy), 64'd0);
    @(negedge clock);
    check("read_rd_en", 64'(mem_rd_en), 64'd1);
    check("read_busy", 64'(busy), 64'd1);
    check("read_valid", 64'(out_valid), 64'd0);
    if (!keep_high) sort_done = 1'b0;
    @(negedge clock);
    check("capt_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    check("send_valid_t3", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_done(input int stall_idx, input int stall_len, input int base_done);
    int stalls;
    int cyc;
    stalls = 0;
    cyc = 0;
    while (done_cnt == base_done && cyc < 3000) begin
      @(posedge clock); #1;
      cyc++;
      if (out_valid && words_seen == stall_idx && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
    end
    check("drain_done_seen", 64'(done_cnt - base_done), 64'd1);
  endtask

  task automatic settle(input int base_done, input int exp_stalls, input bit exp_err);
    repeat (4) @(negedge clock);
    check("drain_done_once", 64'(done_cnt - base_done), 64'd1);
    check("words_per_drain", 64'(words_seen), 64'(DEPTH));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("stall_cycles", 64'(stall_seen), 64'(exp_stalls));
    check("idle_busy", 64'(busy), 64'd0);
    check("final_order_err", 64'(order_err), 64'(exp_err));
  endtask

  typedef struct {
    int base;
    int bad_idx;
    int bad_val;
    int stall_idx;
    int stall_len;
    bit exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base_done;
    int rd_before;
    int cyc;

    vecs[0] = '{0,   -1, 0,  -1, 0, 1'b0};
    vecs[1] = '{0,   -1, 0,   7, 5, 1'b0};
    vecs[2] = '{0,   -1, 0,  31, 3, 1'b0};
    vecs[3] = '{0,    5, -3, -1, 0, CHK};
    vecs[4] = '{0,   -1, 0,  -1, 0, 1'b0};
    vecs[5] = '{-16, -1, 0,  12, 2, 1'b0};

    reset = 1'b0;
    sort_done = 1'b1;
    out_ready = 1'b1;
    fill_mem(0, -1, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(drain_done), 64'd0);
    check("rst_err", 64'(order_err), 64'd0);

    // sort_done already high at release must not start a drain
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("held_level_reads", 64'(rd_cnt), 64'd0);
    check("held_level_busy", 64'(busy), 64'd0);
    check("held_level_valid", 64'(out_valid), 64'd0);
    check("held_level_done", 64'(done_cnt), 64'd0);
    @(posedge clock); #1;
    sort_done = 1'b0;
    repeat (2) @(posedge clock);

    for (int v = 0; v < 6; v++) begin
      fill_mem(vecs[v].base, vecs[v].bad_idx, vecs[v].bad_val);
      base_done = done_cnt;
      start_drain(1'b0);
      wait_done(vecs[v].stall_idx, vecs[v].stall_len, base_done);
      settle(base_done, vecs[v].stall_len, vecs[v].exp_err);
    end

    // Re-trigger while busy is ignored; a level held through REARM does not restart
    fill_mem(0, -1, 0);
    base_done = done_cnt;
    start_drain(1'b1);
    cyc = 0;
    while (words_seen < 10 && cyc < 500) begin
      @(posedge clock); #1;
      cyc++;
    end
    sort_done = 1'b0;
    @(posedge clock); #1;
    sort_done = 1'b1;
    wait_done(-1, 0, base_done);
    settle(base_done, 0, 1'b0);
    rd_before = rd_cnt;
    repeat (5) @(negedge clock);
    check("rearm_no_reads", 64'(rd_cnt - rd_before), 64'd0);
    check("rearm_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    sort_done = 1'b0;
    repeat (2) @(posedge clock);
    base_done = done_cnt;
    start_drain(1'b0);
    wait_done(-1, 0, base_done);
    settle(base_done, 0, 1'b0);

    // Reset during word 12 aborts silently; next edge restarts at address 0
    base_done = done_cnt;
    start_drain(1'b0);
    cyc = 0;
    while (words_seen < 12 && cyc < 500) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("reached_word12", 64'(words_seen), 64'd12);
    reset = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rd_en", 64'(mem_rd_en), 64'd0);
    check("abort_data", 64'(out_data), 64'd0);
    check("abort_last", 64'(out_last), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("abort_no_done", 64'(done_cnt - base_done), 64'd0);
    base_done = done_cnt;
    start_drain(1'b0);
    wait_done(-1, 0, base_done);
    settle(base_done, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
